// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge -> JTFRAME ioctl download sequencer.
// Buffers 32-bit bridge words in a small FIFO and replays each one as four
// byte writes on the ioctl bus, LSB first, paced by prog_rdy from the loader.
// Optional feature macro: JTFRAME_DWNLD_CHKSUM_EN (running byte checksum).
module jtframe_pocket_dwnld #(
    parameter int         DEPTH = 4,
    parameter int         TOUT  = 1023,
    parameter logic [7:0] SKIPA = 8'hF8
)(
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        wr_s,
    input  logic [31:0] addr_s,
    input  logic [31:0] data_s,
    input  logic        ds_done_s,
    input  logic        prog_rdy,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        ioctl_wr,
    output logic        downloading,
    output logic        ovf,
    output logic        tout,
    output logic [15:0] chksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = ($clog2(TOUT + 1) > 10) ? $clog2(TOUT + 1) : 10;
    localparam int QW = 23 + 32;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WR, ST_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic [QW-1:0]   r_hold;
    logic [31:0]     r_qword;
    logic [22:0]     r_waddr;
    logic [1:0]      r_bidx;
    logic [TW-1:0]   r_timer;
    logic            r_dl, r_pend, r_ovf, r_tout;

    logic w_push_req, w_push_ok, w_pop, w_empty, w_adv, w_tmo, w_done, w_dl_rise;
    logic w_unused;

    // Address bits [1:0] are implied by the byte counter, not used from the bridge
    assign w_unused   = ^addr_s[1:0];

    assign w_empty    = (r_count == '0);
    assign w_push_req = wr_s && (addr_s[31:24] != SKIPA);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign w_push_ok  = w_push_req && ((r_count < (AW+1)'(DEPTH)) || w_pop);
    assign w_adv      = prog_rdy || (r_timer == TW'(TOUT));
    assign w_tmo      = (r_state == ST_WAIT) && (r_timer == TW'(TOUT)) && !prog_rdy;
    assign w_done     = r_pend && w_empty && (r_state == ST_IDLE);
    assign w_dl_rise  = w_push_ok && !r_dl;

    assign ioctl_addr  = {r_waddr, r_bidx};
    assign ioctl_dout  = r_qword[7:0];
    assign ioctl_wr    = (r_state == ST_WR);
    assign downloading = r_dl;
    assign ovf         = r_ovf;
    assign tout        = r_tout;

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk_rom) begin
        if (w_push_ok) r_mem[r_wptr] <= {addr_s[24:2], data_s};
    end

    // FIFO pointers, occupancy and the popped-word holding register
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop) begin
                r_hold <= r_mem[r_rptr];
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state and pop request
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_LOAD;
            end
            ST_LOAD: w_state_nxt = ST_WR;
            ST_WR:   w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_adv) begin
                if (r_bidx != 2'd3) begin
                    w_state_nxt = ST_WR;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte serialiser: word latch, byte index and prog_rdy timeout timer
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_qword <= '0;
            r_waddr <= '0;
            r_bidx  <= '0;
            r_timer <= '0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_qword <= r_hold[31:0];
                r_waddr <= r_hold[QW-1:32];
                r_bidx  <= 2'd0;
            end
            if (r_state == ST_WR) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT) begin
                if (w_adv) begin
                    if (r_bidx != 2'd3) begin
                        r_bidx  <= r_bidx + 2'd1;
                        r_qword <= {8'd0, r_qword[31:8]};
                    end
                end else if (r_timer != '1) begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

    // Download window: opens on an accepted word, closes once done is pending and all drained
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_dl   <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (w_push_ok)   r_dl <= 1'b1;
            else if (w_done) r_dl <= 1'b0;
            if (w_done)      r_pend <= 1'b0;
            if (ds_done_s)   r_pend <= 1'b1;
        end
    end

    // Sticky error flags, cleared when a new download opens
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_tout <= 1'b0;
        end else if (w_dl_rise) begin
            r_ovf  <= 1'b0;
            r_tout <= 1'b0;
        end else begin
            if (w_push_req && !w_push_ok) r_ovf  <= 1'b1;
            if (w_tmo)                    r_tout <= 1'b1;
        end
    end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
    logic [15:0] r_chksum;

    // Running sum of every byte written to the loader
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n)         r_chksum <= '0;
        else if (w_dl_rise) r_chksum <= '0;
        else if (ioctl_wr)  r_chksum <= r_chksum + {8'd0, ioctl_dout};
    end

    assign chksum = r_chksum;
`else
    assign chksum = 16'd0;
`endif

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed bench for jtframe_pocket_dwnld (TOUT reduced to 15 for the timeout case).
module tb_jtframe_pocket_dwnld;

    logic        clk_rom = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_s    = 1'b0;
    logic [31:0] addr_s  = '0;
    logic [31:0] data_s  = '0;
    logic        ds_done_s = 1'b0;
    logic        prog_rdy  = 1'b0;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        downloading, ovf, tout;
    logic [15:0] chksum;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int nstrb = 0;
    int served = 0;
    logic [24:0] qa[$];
    logic [7:0]  qd[$];
    int          qc[$];

    jtframe_pocket_dwnld #(.DEPTH(4), .TOUT(15), .SKIPA(8'hF8)) u_dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .wr_s(wr_s), .addr_s(addr_s),
        .data_s(data_s), .ds_done_s(ds_done_s), .prog_rdy(prog_rdy),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .downloading(downloading), .ovf(ovf), .tout(tout), .chksum(chksum)
    );

    always #5 clk_rom = ~clk_rom;

    always @(posedge clk_rom) cyc <= cyc + 1;

    // Log every byte strobe, sampled on the falling edge
    always @(negedge clk_rom) begin
        if (ioctl_wr === 1'b1) begin
            qa.push_back(ioctl_addr);
            qd.push_back(ioctl_dout);
            qc.push_back(cyc);
            nstrb <= nstrb + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_rom);
        #1;
    endtask

    task automatic do_reset();
        wr_s = 0; ds_done_s = 0; prog_rdy = 0;
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        served = nstrb;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, output int c);
        c = cyc;
        wr_s = 1; addr_s = a; data_s = d;
        tick();
        wr_s = 0;
    endtask

    // Answer n strobes, each with prog_rdy a fixed delay after it
    task automatic serve(input int n, input int dly);
        for (int k = 0; k < n; k++) begin
            int lim = 0;
            while (nstrb <= served && lim < 200) begin tick(); lim++; end
            if (nstrb <= served) begin
                chk("serve_wait", 32'(nstrb), 32'(served + 1));
                return;
            end
            served++;
            repeat (dly) tick();
            prog_rdy = 1;
            tick();
            prog_rdy = 0;
        end
    endtask

    task automatic wait_strobes(input int target);
        int lim = 0;
        while (nstrb < target && lim < 300) begin tick(); lim++; end
        if (nstrb < target) chk("strobe_wait", 32'(nstrb), 32'(target));
    endtask

    initial begin
        int c, base;
        logic [15:0] exp_ck;

        // Reset state
        repeat (2) tick();
        chk("rst_addr", 32'(ioctl_addr), 0);
        chk("rst_dout", 32'(ioctl_dout), 0);
        chk("rst_wr",   32'(ioctl_wr), 0);
        chk("rst_dl",   32'(downloading), 0);
        chk("rst_ovf",  32'(ovf), 0);
        chk("rst_tout", 32'(tout), 0);
        chk("rst_ck",   32'(chksum), 0);
        rst_n = 1;
        tick();
        served = nstrb;

        // 1: single word, four bytes LSB first, 3-cycle latency
        base = qa.size();
        push(32'h0000_0010, 32'h4433_2211, c);
        chk("t1_dl", 32'(downloading), 1);
        serve(4, 1);
        repeat (4) tick();
        chk("t1_cnt", 32'(qa.size() - base), 4);
        chk("t1_lat", 32'(qc[base] - c), 3);
        for (int j = 0; j < 4; j++) begin
            chk("t1_addr", 32'(qa[base+j]), 32'h10 + 32'(j));
            chk("t1_dout", 32'(qd[base+j]), 32'h11 * 32'(j + 1));
        end
        chk("t1_ovf", 32'(ovf), 0);
        chk("t1_tout", 32'(tout), 0);

        // 2: six-word burst into a depth-4 FIFO while the loader stalls
        do_reset();
        base = qa.size();
        for (int k = 0; k < 6; k++)
            push(32'h100 + 32'(4*k), {4'(k), 4'd3, 4'(k), 4'd2, 4'(k), 4'd1, 4'(k), 4'd0}, c);
        repeat (6) tick();
        chk("t2_ovf", 32'(ovf), 1);
        serve(20, 1);
        repeat (20) tick();
        chk("t2_cnt", 32'(qa.size() - base), 20);
        chk("t2_tout", 32'(tout), 0);
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) begin
                chk("t2_addr", 32'(qa[base+4*k+j]), 32'h100 + 32'(4*k + j));
                chk("t2_dout", 32'(qd[base+4*k+j]), 32'(16*k + j));
            end

        // 3: bridge write to the skipped region is ignored
        do_reset();
        base = qa.size();
        push(32'hF800_0020, 32'hDEAD_BEEF, c);
        repeat (10) tick();
        chk("t3_cnt", 32'(qa.size() - base), 0);
        chk("t3_dl",  32'(downloading), 0);
        chk("t3_ovf", 32'(ovf), 0);

        // 4: done pulse with two words still queued
        do_reset();
        base = qa.size();
        for (int k = 0; k < 3; k++) push(32'h200 + 32'(4*k), 32'h0102_0304, c);
        ds_done_s = 1;
        tick();
        ds_done_s = 0;
        chk("t4_dl_q", 32'(downloading), 1);
        serve(12, 1);
        chk("t4_dl_last", 32'(downloading), 1);
        tick();
        chk("t4_dl_fall", 32'(downloading), 0);
        chk("t4_cnt", 32'(qa.size() - base), 12);

        // 5: loader never answers -> timeout paces the strobes
        do_reset();
        base = qa.size();
        push(32'h0000_0040, 32'h8765_4321, c);
        wait_strobes(served + 4);
        repeat (40) tick();
        chk("t5_cnt", 32'(qa.size() - base), 4);
        for (int j = 1; j < 4; j++) chk("t5_gap", 32'(qc[base+j] - qc[base+j-1]), 17);
        chk("t5_b3", 32'(qd[base+3]), 32'h87);
        chk("t5_tout", 32'(tout), 1);

        // 6: checksum over two all-ones words, then reset mid-word
        do_reset();
        push(32'h0, 32'hFFFF_FFFF, c);
        push(32'h4, 32'hFFFF_FFFF, c);
        serve(8, 1);
        repeat (4) tick();
`ifdef JTFRAME_DWNLD_CHKSUM_EN
        exp_ck = 16'h07F8;
`else
        exp_ck = 16'h0000;
`endif
        chk("t6_ck", 32'(chksum), 32'(exp_ck));
        push(32'h80, 32'h1234_5678, c);
        wait_strobes(nstrb + 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_addr", 32'(ioctl_addr), 0);
        chk("t6_dout", 32'(ioctl_dout), 0);
        chk("t6_wr",   32'(ioctl_wr), 0);
        chk("t6_dl",   32'(downloading), 0);
        chk("t6_ck0",  32'(chksum), 0);
        base = qa.size();
        tick();
        rst_n = 1;
        repeat (20) tick();
        chk("t6_abort", 32'(qa.size() - base), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
